// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MIN_WIDTH = 2;

  // Borrow-out of one full-subtractor bit: x - y - bin.
  function automatic logic borrow_out(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface sub_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (output en, a, b, input out, borrow, busy, done);
  modport slave  (input en, a, b, output out, borrow, busy, done);
endinterface

// File: rtl/sub_serial_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow-out.
module full_sub_cell
  import sub_serial_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = borrow_out(x, y, bin);
endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor, out = a - b, LSB first, one bit per clock.
// Build option SUB_SERIAL_SAT_EN: saturate the result at zero on underflow.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  sub_serial_if.slave bus
);
  if (WIDTH < MIN_WIDTH) begin : g_width_check
    $error("sub_serial: WIDTH must be >= %0d", MIN_WIDTH);
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;
  logic             cell_d, cell_bout;

  full_sub_cell u_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bout(cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          a_d      = bus.a;
          b_d      = bus.b;
          out_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SUB;
        end
      end
      SUB: begin
        borrow_d = cell_bout;
        out_d    = {cell_d, out_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SUB_SERIAL_SAT_EN
          if (cell_bout) out_d = '0;
`endif
        end
      end
      DONE: begin
        if (!bus.en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == SUB);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.out    = out_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
